// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Operand-fetch pipeline stage sitting between decode and the ALU. It owns the
// writable GPR bank and a fixed, read-only constant bank. For each incoming
// instruction both operands (source and destination) are resolved from either
// bank, selected by the per-instruction rc bit. GPR reads see forwarding from
// the execute stage and write-through from writeback. The resolved operands are
// captured into a single valid/ready output slot feeding execute.
//
// Build option:
//   OPERAND_FWD_EN  defined   : execute-stage result forwarding is active.
//                   undefined : no execute forwarding; an instruction whose GPR
//                               operand matches a pending execute result is
//                               held back (in_ready low) until the hazard clears.
//
// Parameters:
//   DATA_W    operand / register width
//   NUM_REGS  registers per bank (power of two, >= 8)
//   IDX_W     register index width (derived)
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               decode-side handshake
//   in_rc, in_src_idx, in_dst_idx   bank select and operand indices
//   wb_en, wb_idx, wb_data          writeback GPR write port
//   ex_fwd_valid/idx/data           execute-stage result for forwarding
//   out_valid/out_ready             execute-side handshake
//   out_rc, out_src_idx, out_dst_idx registered instruction fields
//   src_val, dst_val                registered resolved operands
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 8,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rc,
    input  logic [IDX_W-1:0]  in_src_idx,
    input  logic [IDX_W-1:0]  in_dst_idx,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_fwd_valid,
    input  logic [IDX_W-1:0]  ex_fwd_idx,
    input  logic [DATA_W-1:0] ex_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rc,
    output logic [IDX_W-1:0]  out_src_idx,
    output logic [IDX_W-1:0]  out_dst_idx,
    output logic [DATA_W-1:0] src_val,
    output logic [DATA_W-1:0] dst_val
);

    // Constant bank: 0, 1, 2, 4, 8, 16, 32, all-ones; anything above 7 reads 0.
    function automatic logic [DATA_W-1:0] const_val(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        case (idx)
            IDX_W'(32'd0): v = '0;
            IDX_W'(32'd1): v = DATA_W'(32'd1);
            IDX_W'(32'd2): v = DATA_W'(32'd2);
            IDX_W'(32'd3): v = DATA_W'(32'd4);
            IDX_W'(32'd4): v = DATA_W'(32'd8);
            IDX_W'(32'd5): v = DATA_W'(32'd16);
            IDX_W'(32'd6): v = DATA_W'(32'd32);
            IDX_W'(32'd7): v = '1;
            default:       v = '0;
        endcase
        return v;
    endfunction

    // One operand: constants bypass forwarding; execute result is younger than
    // writeback so it wins when both target the same GPR.
    function automatic logic [DATA_W-1:0] resolve(
        input logic              rc,
        input logic [IDX_W-1:0]  idx,
        input logic [DATA_W-1:0] gpr_val,
        input logic              fwd_v,
        input logic [IDX_W-1:0]  fwd_idx,
        input logic [DATA_W-1:0] fwd_data,
        input logic              wb_v,
        input logic [IDX_W-1:0]  wbi,
        input logic [DATA_W-1:0] wbd
    );
        logic [DATA_W-1:0] v;
        if (rc) begin
            v = const_val(idx);
        end else if (fwd_v && (fwd_idx == idx)) begin
            v = fwd_data;
        end else if (wb_v && (wbi == idx)) begin
            v = wbd;
        end else begin
            v = gpr_val;
        end
        return v;
    endfunction

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] gpr_d [NUM_REGS];

    logic              out_valid_q,   out_valid_d;
    logic              out_rc_q,      out_rc_d;
    logic [IDX_W-1:0]  out_src_idx_q, out_src_idx_d;
    logic [IDX_W-1:0]  out_dst_idx_q, out_dst_idx_d;
    logic [DATA_W-1:0] src_val_q,     src_val_d;
    logic [DATA_W-1:0] dst_val_q,     dst_val_d;

    logic              fwd_path_en_s;
    logic              hazard_s;
    logic              accept_s;
    logic [DATA_W-1:0] src_res_s;
    logic [DATA_W-1:0] dst_res_s;

`ifdef OPERAND_FWD_EN
    assign fwd_path_en_s = ex_fwd_valid;
    assign hazard_s      = 1'b0;
`else
    // Without forwarding, a GPR read of a pending execute result must wait.
    assign fwd_path_en_s = 1'b0;
    assign hazard_s      = in_valid && !in_rc && ex_fwd_valid &&
                           ((ex_fwd_idx == in_src_idx) || (ex_fwd_idx == in_dst_idx));
`endif

    assign in_ready = (!out_valid_q || out_ready) && !hazard_s;
    assign accept_s = in_valid && in_ready;

    assign src_res_s = resolve(in_rc, in_src_idx, gpr_q[in_src_idx], fwd_path_en_s,
                               ex_fwd_idx, ex_fwd_data, wb_en, wb_idx, wb_data);
    assign dst_res_s = resolve(in_rc, in_dst_idx, gpr_q[in_dst_idx], fwd_path_en_s,
                               ex_fwd_idx, ex_fwd_data, wb_en, wb_idx, wb_data);

    // GPR bank next state: writeback is independent of pipeline flow.
    always_comb begin
        gpr_d = gpr_q;
        if (wb_en) begin
            gpr_d[wb_idx] = wb_data;
        end else begin
            gpr_d = gpr_q;
        end
    end

    // Output slot next state: load on accept, drain on consume, else hold.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_rc_d      = out_rc_q;
        out_src_idx_d = out_src_idx_q;
        out_dst_idx_d = out_dst_idx_q;
        src_val_d     = src_val_q;
        dst_val_d     = dst_val_q;
        if (accept_s) begin
            out_valid_d   = 1'b1;
            out_rc_d      = in_rc;
            out_src_idx_d = in_src_idx;
            out_dst_idx_d = in_dst_idx;
            src_val_d     = src_res_s;
            dst_val_d     = dst_res_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_rc_q      <= 1'b0;
            out_src_idx_q <= '0;
            out_dst_idx_q <= '0;
            src_val_q     <= '0;
            dst_val_q     <= '0;
        end else begin
            gpr_q         <= gpr_d;
            out_valid_q   <= out_valid_d;
            out_rc_q      <= out_rc_d;
            out_src_idx_q <= out_src_idx_d;
            out_dst_idx_q <= out_dst_idx_d;
            src_val_q     <= src_val_d;
            dst_val_q     <= dst_val_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rc      = out_rc_q;
    assign out_src_idx = out_src_idx_q;
    assign out_dst_idx = out_dst_idx_q;
    assign src_val     = src_val_q;
    assign dst_val     = dst_val_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Self-checking bench for operand_fetch_stage (DATA_W=16, NUM_REGS=8). A bench
// model of the GPR bank and a scoreboard queue of captured instructions predict
// in_ready and every output each cycle; scenario tasks add direct checks
// against literal values. Honours OPERAND_FWD_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_rc;
    logic [IDX_W-1:0]  in_src_idx;
    logic [IDX_W-1:0]  in_dst_idx;
    logic              wb_en;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic              ex_fwd_valid;
    logic [IDX_W-1:0]  ex_fwd_idx;
    logic [DATA_W-1:0] ex_fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_rc;
    logic [IDX_W-1:0]  out_src_idx;
    logic [IDX_W-1:0]  out_dst_idx;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] dst_val;

    operand_fetch_stage #(.DATA_W(DATA_W), .NUM_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rc(in_rc),
        .in_src_idx(in_src_idx), .in_dst_idx(in_dst_idx),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rc(out_rc),
        .out_src_idx(out_src_idx), .out_dst_idx(out_dst_idx),
        .src_val(src_val), .dst_val(dst_val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rc;
        logic [IDX_W-1:0]  s;
        logic [IDX_W-1:0]  d;
        logic [DATA_W-1:0] sv;
        logic [DATA_W-1:0] dv;
    } ent_t;

    ent_t              sb_q[$];
    ent_t              last_m;
    logic [DATA_W-1:0] gpr_m [8];
    int                n_vec = 0;
    int                n_err = 0;

`ifdef OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] exp_op(input logic rc, input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] tbl [8];
        tbl = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'hFFFF};
        if (rc)                                       return tbl[idx];
        else if (FWD && ex_fwd_valid && ex_fwd_idx == idx) return ex_fwd_data;
        else if (wb_en && wb_idx == idx)              return wb_data;
        else                                          return gpr_m[idx];
    endfunction

    // One clock: check in_ready before the edge, update model at the edge,
    // check every output just after it.
    task automatic cycle();
        logic hz, rdy;
        ent_t e;
        @(negedge clk);
        hz  = !FWD && in_valid && !in_rc && ex_fwd_valid &&
              (ex_fwd_idx == in_src_idx || ex_fwd_idx == in_dst_idx);
        rdy = (sb_q.size() == 0 || out_ready) && !hz;
        n_vec++;
        if (in_ready !== rdy) begin
            n_err++;
            $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, rdy);
        end
        e = '{in_rc, in_src_idx, in_dst_idx, exp_op(in_rc, in_src_idx), exp_op(in_rc, in_dst_idx)};
        @(posedge clk);
        if (!rst_n) begin
            sb_q.delete();
            last_m = '0;
            for (int i = 0; i < 8; i++) gpr_m[i] = '0;
        end else begin
            if (sb_q.size() > 0 && out_ready) void'(sb_q.pop_front());
            if (in_valid && rdy) begin
                sb_q.push_back(e);
                last_m = e;
            end
            if (wb_en) gpr_m[wb_idx] = wb_data;
        end
        #1;
        n_vec++;
        if (out_valid !== (sb_q.size() > 0)) begin
            n_err++;
            $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, sb_q.size() > 0);
        end
        n_vec++;
        if ({out_rc, out_src_idx, out_dst_idx, src_val, dst_val} !== last_m) begin
            n_err++;
            $display("FAIL out_fields t=%0t got rc=%b s=%0d d=%0d sv=%h dv=%h exp rc=%b s=%0d d=%0d sv=%h dv=%h",
                     $time, out_rc, out_src_idx, out_dst_idx, src_val, dst_val,
                     last_m.rc, last_m.s, last_m.d, last_m.sv, last_m.dv);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_rc = 1'b0; in_src_idx = '0; in_dst_idx = '0;
        wb_en = 1'b0; wb_idx = '0; wb_data = '0;
        ex_fwd_valid = 1'b0; ex_fwd_idx = '0; ex_fwd_data = '0;
        out_ready = 1'b1;
    endtask

    task automatic issue(input logic rc, input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d);
        in_valid = 1'b1; in_rc = rc; in_src_idx = s; in_dst_idx = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        last_m = '0;
        for (int i = 0; i < 8; i++) gpr_m[i] = '0;
        n_vec++;
        if ({out_valid, out_rc, out_src_idx, out_dst_idx, src_val, dst_val} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b sv=%h dv=%h exp all zero", out_valid, src_val, dst_val);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        wb_en = 1'b1; wb_idx = 3'd3; wb_data = 16'h1234;
        cycle();
        wb_en = 1'b0;
        issue(1'b0, 3'd3, 3'd0);
        cycle();
        in_valid = 1'b0;
        n_vec++;
        if (!(out_valid === 1'b1 && src_val === 16'h1234 && dst_val === 16'h0000)) begin
            n_err++;
            $display("FAIL basic got v=%b sv=%h dv=%h exp v=1 sv=1234 dv=0000", out_valid, src_val, dst_val);
        end
        cycle();
    endtask

    task automatic test_const();
        ex_fwd_valid = 1'b1; ex_fwd_idx = 3'd6; ex_fwd_data = 16'h9999;
        issue(1'b1, 3'd6, 3'd7);
        cycle();
        n_vec++;
        if (!(src_val === 16'h0020 && dst_val === 16'hFFFF)) begin
            n_err++;
            $display("FAIL const_nofwd got sv=%h dv=%h exp sv=0020 dv=ffff", src_val, dst_val);
        end
        ex_fwd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 3'(i), 3'(7 - i));
            cycle();
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_fwd_priority();
        wb_en = 1'b1; wb_idx = 3'd2; wb_data = 16'h0001;
        cycle();
        wb_data = 16'h5555;
        ex_fwd_valid = 1'b1; ex_fwd_idx = 3'd2; ex_fwd_data = 16'hAAAA;
        issue(1'b0, 3'd2, 3'd2);
        cycle();
        n_vec++;
        if (FWD) begin
            if (!(out_valid === 1'b1 && src_val === 16'hAAAA && dst_val === 16'hAAAA)) begin
                n_err++;
                $display("FAIL fwd_priority got v=%b sv=%h dv=%h exp v=1 aaaa aaaa", out_valid, src_val, dst_val);
            end
        end else begin
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hazard_stall got v=%b exp 0", out_valid);
            end
        end
        // Hazard gone: retry sees the written-back value (or recaptures in fwd build).
        wb_en = 1'b0; ex_fwd_valid = 1'b0;
        cycle();
        n_vec++;
        if (!(out_valid === 1'b1 && src_val === 16'h5555)) begin
            n_err++;
            $display("FAIL fwd_retry got v=%b sv=%h exp v=1 sv=5555", out_valid, src_val);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_write_through();
        wb_en = 1'b1; wb_idx = 3'd5; wb_data = 16'h00FF;
        issue(1'b0, 3'd5, 3'd3);
        cycle();
        wb_en = 1'b0;
        n_vec++;
        if (src_val !== 16'h00FF) begin
            n_err++;
            $display("FAIL write_through got %h exp 00ff", src_val);
        end
        issue(1'b0, 3'd4, 3'd5);
        cycle();
        n_vec++;
        if (dst_val !== 16'h00FF) begin
            n_err++;
            $display("FAIL wt_stored got %h exp 00ff", dst_val);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_stall();
        wb_en = 1'b1; wb_idx = 3'd1; wb_data = 16'hBEEF;
        cycle();
        wb_en = 1'b0;
        issue(1'b0, 3'd1, 3'd3);
        cycle();
        out_ready = 1'b0;
        issue(1'b0, 3'd3, 3'd1);
        for (int i = 0; i < 3; i++) begin
            wb_en = (i == 1); wb_idx = 3'd1; wb_data = 16'h0BAD;
            cycle();
        end
        wb_en = 1'b0;
        n_vec++;
        if (!(out_valid === 1'b1 && src_val === 16'hBEEF && out_src_idx === 3'd1)) begin
            n_err++;
            $display("FAIL stall_frozen got v=%b sv=%h s=%0d exp v=1 sv=beef s=1", out_valid, src_val, out_src_idx);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_vec++;
        if (!(out_valid === 1'b1 && dst_val === 16'h0BAD && out_src_idx === 3'd3)) begin
            n_err++;
            $display("FAIL stall_release got v=%b dv=%h s=%0d exp v=1 dv=0bad s=3", out_valid, dst_val, out_src_idx);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_rc        = ($urandom_range(0, 3) == 0);
            in_src_idx   = 3'($urandom_range(0, 7));
            in_dst_idx   = 3'($urandom_range(0, 7));
            out_ready    = (i < 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
            wb_en        = ($urandom_range(0, 1) == 1);
            wb_idx       = 3'($urandom_range(0, 7));
            wb_data      = 16'($urandom);
            ex_fwd_valid = (i >= 10) && ($urandom_range(0, 3) == 0);
            ex_fwd_idx   = 3'($urandom_range(0, 7));
            ex_fwd_data  = 16'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_stall();
        wb_en = 1'b1; wb_idx = 3'd6; wb_data = 16'hC0DE;
        issue(1'b0, 3'd6, 3'd6);
        cycle();
        wb_en = 1'b0;
        out_ready = 1'b0;
        issue(1'b0, 3'd2, 3'd2);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_vec++;
        if ({out_valid, out_rc, out_src_idx, out_dst_idx, src_val, dst_val} !== '0) begin
            n_err++;
            $display("FAIL reset_stall got v=%b sv=%h dv=%h exp all zero", out_valid, src_val, dst_val);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 3'(2 * i), 3'(2 * i + 1));
            cycle();
        end
        in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_const();
        test_fwd_priority();
        test_write_through();
        test_stall();
        test_back_to_back();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
